// File: rtl/bram_port_client.sv
// Request/response front end for one port of a byte-write, read-first BRAM with registered output.
// Optional macro BRAM_PORT_WRITE_RESP_EN: writes also return a read-first response.
module bram_port_client #(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int ADDR_W    = 10,
  parameter int RSP_DEPTH = 4
) (
  input  logic                        clka,
  input  logic                        rsta_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [NB_COL-1:0]           req_we,
  input  logic [NB_COL*COL_WIDTH-1:0] req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [NB_COL*COL_WIDTH-1:0] rsp_rdata,
  output logic                        ram_en,
  output logic [NB_COL-1:0]           ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0] ram_din,
  output logic                        ram_regce,
  output logic                        ram_rst,
  input  logic [NB_COL*COL_WIDTH-1:0] ram_dout
);

  localparam int DW    = NB_COL * COL_WIDTH;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [DW-1:0]     buf_q [RSP_DEPTH];

  logic              accept;
  logic              need_rsp;
  logic              credit_ok;
  logic              buf_empty;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    inflight;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover every response that may still land: both pipeline bits plus buffered entries.
  always_comb begin
    inflight  = {{CNT_W{1'b0}}, v1_q} + {{CNT_W{1'b0}}, v2_q} + {1'b0, cnt_q};
    credit_ok = (inflight < DEPTH_C);
    req_ready = credit_ok | ~rsta_n;
    accept    = req_valid & req_ready & rsta_n;
  end

  always_comb begin
`ifdef BRAM_PORT_WRITE_RESP_EN
    need_rsp = accept;
`else
    need_rsp = accept & ~(|req_we);
`endif
  end

  always_comb begin
    ram_en    = accept;
    ram_we    = req_we & {NB_COL{accept}};
    ram_addr  = req_addr;
    ram_din   = req_wdata;
    ram_regce = v1_q & rsta_n;
    ram_rst   = ~rsta_n;
  end

  // The buffer head always wins so responses leave in request order.
  always_comb begin
    buf_empty = (cnt_q == '0);
    rsp_valid = rsta_n & (~buf_empty | v2_q);
    rsp_rdata = '0;
    if (rsta_n) begin
      if (!buf_empty) begin
        rsp_rdata = buf_q[rd_q];
      end else if (v2_q) begin
        rsp_rdata = ram_dout;
      end
    end
    pop  = rsta_n & ~buf_empty & rsp_ready;
    push = rsta_n & v2_q & (~buf_empty | ~rsp_ready);
  end

  always_comb begin
    v1_d  = need_rsp;
    v2_d  = v1_q;
    cnt_d = cnt_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      wr_d = next_ptr(wr_q);
    end
    if (pop) begin
      rd_d = next_ptr(rd_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge clka) begin
    if (push) begin
      buf_q[wr_q] <= ram_dout;
    end
  end

endmodule

// File: doc/bram_port_client.md
# bram_port_client

Request/response front end that drives one port of the team's byte-write, read-first, dual-port block RAM when that RAM is configured for two-cycle (output-registered) read latency. It accepts valid/ready requests from a core-side master, generates the RAM enable, write-enable, output-register-enable and output-reset signals, and tracks reads in flight. It returns read data through a credit-limited response buffer, so back-pressure on the response side never loses data. One instance sits in front of each RAM port, for example an instruction-fetch port and a load/store port.

## Interface
- NB_COL, 4, byte lanes per word
- COL_WIDTH, 8, bits per lane
- ADDR_W, 10, word address width
- RSP_DEPTH, 4, response buffer entries; minimum 3
- clka  in  1  clock, shared with the RAM
- rsta_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_addr  in  ADDR_W  word address
- req_we  in  NB_COL  per-lane write enable; all zero means read
- req_wdata  in  NB_COL*COL_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  NB_COL*COL_WIDTH  response data
- ram_en  out  1  RAM port enable
- ram_we  out  NB_COL  RAM lane write enables
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  NB_COL*COL_WIDTH  RAM write data
- ram_regce  out  1  RAM output register enable
- ram_rst  out  1  RAM output register reset, active-high
- ram_dout  in  NB_COL*COL_WIDTH  RAM registered output

## Operation
- Accept: a request is accepted when req_valid and req_ready are both high at a clka edge.
- RAM drive: during the accept cycle, the RAM signals follow the request combinationally.
  - ram_en = req_valid & req_ready.
  - ram_we = req_we & {NB_COL{accept}}.
  - ram_addr = req_addr.
  - ram_din = req_wdata.
- Response tracking: a request that needs a response sets pipeline bit v1 at the accept edge. v1 moves to v2 on the next edge.
- Output register: ram_regce = v1. ram_rst = ~rsta_n.
- Response source, during a cycle where v2 is high (ram_dout valid):
  - Buffer empty: ram_dout is presented directly on rsp_rdata with rsp_valid high.
  - If it is not consumed in that cycle, or the buffer is not empty, ram_dout is pushed into the buffer at the end of the cycle.
- Buffer: FIFO, show-ahead. When the buffer is non-empty, its head drives rsp_rdata and rsp_valid is high. Responses are always returned in request order.
- Credit rule: req_ready = (v1 + v2 + count) < RSP_DEPTH.
  - The term is combinational from registered state only; it never depends on rsp_ready or req_valid.
  - A push and a pop at the same edge leave count unchanged.
- Writes: byte lanes with req_we low keep their contents. The read-first data a write produces is discarded, unless the macro in Configuration is defined.
- Reset (rsta_n low at an edge) clears v1, v2, the buffer count and the FIFO pointers.
  - A reset mid-operation discards all in-flight responses.
  - Writes already accepted remain in the RAM; RAM contents are never cleared.

## Timing
- Read latency: accept at edge E0, response visible in the cycle after edge E1 (2 cycles) when the buffer is empty.
- Throughput: one request per cycle is sustained with rsp_ready held high and RSP_DEPTH >= 3.
- rsp_ready low: at most RSP_DEPTH responses are outstanding; req_ready falls once the limit is reached.
- Output values during and directly after reset:
  - rsp_valid = 0, req_ready = 1, ram_en = 0, ram_we = 0, ram_regce = 0.
  - ram_rst = 1 while rsta_n is low.
  - rsp_rdata = 0 when nothing is valid.
- rsp_valid, once high, stays high with rsp_rdata stable until it is consumed.

## Configuration
- BRAM_PORT_WRITE_RESP_EN
  - Defined: every accepted request, including writes, takes a credit and returns one response. For a write, the response carries the prior contents of the whole word (read-first).
  - Undefined: writes take no credit and produce no response; only reads (req_we == 0) set v1.

## Test plan
- Reset, then read address 0x005 in a RAM preloaded with 0xA5A5A5A5 -> ram_en pulses one cycle, rsp_valid high 2 cycles after the accept with rsp_rdata = 0xA5A5A5A5.
- Write 0x11223344 with req_we = 4'b0101 to address 0x010 holding 0xFFFFFFFF, then read it -> read returns 0xFF22FF44. With the macro defined, the write itself first returns 0xFFFFFFFF.
- Back-to-back reads of addresses 0..7 with rsp_ready held high -> req_ready stays high, 8 responses arrive on consecutive cycles starting 2 cycles after the first accept, in order.
- rsp_ready held low, 6 reads offered -> exactly 4 accepted, then req_ready = 0. Releasing rsp_ready drains 4 in-order responses, then the remaining 2 are accepted.
- Simultaneous push and pop with the buffer holding 2 entries -> count stays 2, no duplicated or lost data.
- rsta_n low for 1 cycle while 3 reads are in flight -> no further rsp_valid, req_ready = 1 on the next cycle, a later read returns correct data.
